ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-002 It SHALL have these pipeline-control inputs:
- stall  in  1  hold all state
- flush  in  1  insert bubble
- valid_in  in  1  ID/EX slot holds a real instruction
REQ-003 It SHALL have these ID/EX inputs:
- pc_in  in  16  PC+1
- mem_to_reg_in  in  1
- reg_to_mem_in  in  1
- alu_op_in  in  3
- alu_src_in  in  1
- shift_in  in  4
- sign_ext_in  in  16
- load_half_imm_in  in  8
- branch_in  in  4  [3]=enable, [2:0]=condition
- rd_data_0_in  in  16
- rd_data_1_in  in  16
- call_in  in  12
- call_en_in  in  1
REQ-004 It SHALL have these EX/MEM outputs, all registered:
- alu_result_out  out  16
- store_data_out  out  16
- mem_to_reg_out  out  1
- reg_to_mem_out  out  1
- valid_out  out  1
- branch_taken_out  out  1
- branch_target_out  out  16
- flags_out  out  3  {Z,V,N}

Function
REQ-005 The block SHALL select operands as A=rd_data_0_in, and B=sign_ext_in when alu_src_in=1, else rd_data_1_in.
REQ-006 alu_op_in SHALL select the operation: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 NOR; 100 SLL A<<shift_in; 101 SRL; 110 SRA; 111 LHB {load_half_imm_in, A[7:0]}.
REQ-007 ADD/SUB SHALL use 16-bit two's-complement arithmetic; V = signed overflow.
REQ-008 Flag register {Z,V,N} update rules:
- ADD/SUB update Z, V and N.
- AND/NOR/shifts update Z only; V and N hold.
- LHB updates no flag.
REQ-009 Flags SHALL update only on a rising edge with valid_in=1, stall=0, flush=0, rst=0; flags_out SHALL be the flag register.
REQ-010 The branch condition SHALL be evaluated on the flag register value before the current instruction's update: 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|!N; 101 N|Z; 110 V; 111 always.
REQ-011 branch_taken_out SHALL be registered as valid_in & ((branch_in[3] & condition) | call_en_in).
REQ-012 branch_target_out SHALL be pc_in + sign_ext_in, or pc_in + sext(call_in) when call_en_in=1; addition wraps modulo 2^16.
REQ-013 store_data_out SHALL be registered rd_data_1_in; mem_to_reg_out and reg_to_mem_out SHALL be registered inputs ANDed with valid_in.
REQ-014 Latency SHALL be exactly one cycle from the ID/EX inputs to all outputs.
REQ-015 When stall=1 (and flush=0), all outputs and flags SHALL hold their values.
REQ-016 When flush=1, the next edge SHALL clear valid_out, mem_to_reg_out, reg_to_mem_out and branch_taken_out, leave flags unchanged, and leave the other outputs don't-care.
REQ-017 Priority SHALL be rst > flush > stall > normal; simultaneous flush and stall SHALL flush.
REQ-018 An invalid slot (valid_in=0) SHALL produce valid_out=0, mem_to_reg_out=0, reg_to_mem_out=0, branch_taken_out=0 and no flag update.

Reset
REQ-019 On a rising edge with rst=1, all outputs and the flag register SHALL clear to 0.
REQ-020 Reset mid-stall or mid-flush SHALL take priority.
REQ-021 The first valid instruction after rst is released SHALL see flags {0,0,0}.

Configuration
REQ-022 The macro SAT_ARITH_EN SHALL control ADD/SUB overflow behaviour:
- Defined: on overflow, ADD/SUB results saturate to 16'h7FFF when the true result is positive and to 16'h8000 when it is negative; V=1; N follows the saturated value.
- Undefined: results wrap; V=1 on overflow.
- All other operations are identical in both builds.

Verification
REQ-023 ADD A=16'h7FFF, B=16'h0001, valid -> next cycle: with SAT_ARITH_EN alu_result_out=16'h7FFF; without it 16'h8000; V=1 in both.
REQ-024 SUB A=5, B=5 (Z becomes 1); next instruction branch_in=4'b1001, pc_in=16'h0010, sign_ext_in=16'hFFFE -> branch_taken_out=1, branch_target_out=16'h000E.
REQ-025 LHB A=16'h12AB, imm=8'hCD -> alu_result_out=16'hCDAB; flags unchanged.
REQ-026 SW instruction (reg_to_mem_in=1) with stall=1 and flush=1 together -> reg_to_mem_out=0 and valid_out=0; flags unchanged.
REQ-027 Stall held 3 cycles after SRA A=16'h8000, shift_in=4 -> alu_result_out=16'hF800 stable for all 3 cycles.
REQ-028 rst asserted during a stream of ADDs -> all outputs 0 at the next edge; the first post-reset branch with condition 001 (EQ) is not taken.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX inputs, pipeline controls and EX/MEM outputs
// of the execute stage.
//   master : drives controls and ID/EX fields, observes EX/MEM results
//   slave  : the execute stage itself
interface ex_stage_if;
    // pipeline control
    logic        stall;
    logic        flush;
    logic        valid_in;
    // ID/EX fields
    logic [15:0] pc_in;
    logic        mem_to_reg_in;
    logic        reg_to_mem_in;
    logic [2:0]  alu_op_in;
    logic        alu_src_in;
    logic [3:0]  shift_in;
    logic [15:0] sign_ext_in;
    logic [7:0]  load_half_imm_in;
    logic [3:0]  branch_in;
    logic [15:0] rd_data_0_in;
    logic [15:0] rd_data_1_in;
    logic [11:0] call_in;
    logic        call_en_in;
    // EX/MEM results
    logic [15:0] alu_result_out;
    logic [15:0] store_data_out;
    logic        mem_to_reg_out;
    logic        reg_to_mem_out;
    logic        valid_out;
    logic        branch_taken_out;
    logic [15:0] branch_target_out;
    logic [2:0]  flags_out;

    modport master (
        output stall, flush, valid_in, pc_in, mem_to_reg_in, reg_to_mem_in, alu_op_in,
               alu_src_in, shift_in, sign_ext_in, load_half_imm_in, branch_in,
               rd_data_0_in, rd_data_1_in, call_in, call_en_in,
        input  alu_result_out, store_data_out, mem_to_reg_out, reg_to_mem_out, valid_out,
               branch_taken_out, branch_target_out, flags_out
    );

    modport slave (
        input  stall, flush, valid_in, pc_in, mem_to_reg_in, reg_to_mem_in, alu_op_in,
               alu_src_in, shift_in, sign_ext_in, load_half_imm_in, branch_in,
               rd_data_0_in, rd_data_1_in, call_in, call_en_in,
        output alu_result_out, store_data_out, mem_to_reg_out, reg_to_mem_out, valid_out,
               branch_taken_out, branch_target_out, flags_out
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 16-bit pipeline. ALU, {Z,V,N} flag register,
// branch/call resolution, all results registered with one cycle latency.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears outputs and flags)
//   bus  : ex_stage_if.slave (controls, ID/EX fields, EX/MEM results)
// Build option: define SAT_ARITH_EN to make ADD/SUB saturate on signed
// overflow instead of wrapping.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    typedef enum logic [2:0] {
        OpAdd = 3'b000, OpSub = 3'b001, OpAnd = 3'b010, OpNor = 3'b011,
        OpSll = 3'b100, OpSrl = 3'b101, OpSra = 3'b110, OpLhb = 3'b111
    } alu_op_e;

    logic [2:0]  flags_q;           // {Z,V,N}
    logic        flag_z, flag_v, flag_n;
    logic [15:0] op_a, op_b;
    logic [15:0] sum, diff, arith, result;
    logic        ovf, upd_zvn, upd_z, cond, taken;
    logic [15:0] target;

    assign flag_z = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_n = flags_q[0];

    always_comb begin
        op_a    = bus.rd_data_0_in;
        op_b    = bus.alu_src_in ? bus.sign_ext_in : bus.rd_data_1_in;
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        ovf     = 1'b0;
        arith   = sum;
        result  = 16'h0000;
        upd_zvn = 1'b0;
        upd_z   = 1'b0;
        unique case (alu_op_e'(bus.alu_op_in))
            OpAdd: begin
                arith   = sum;
                ovf     = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
                upd_zvn = 1'b1;
            end
            OpSub: begin
                arith   = diff;
                ovf     = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
                upd_zvn = 1'b1;
            end
            OpAnd: begin result = op_a & op_b;    upd_z = 1'b1; end
            OpNor: begin result = ~(op_a | op_b); upd_z = 1'b1; end
            OpSll: begin result = op_a << bus.shift_in; upd_z = 1'b1; end
            OpSrl: begin result = op_a >> bus.shift_in; upd_z = 1'b1; end
            OpSra: begin result = 16'($signed(op_a) >>> bus.shift_in); upd_z = 1'b1; end
            OpLhb: result = {bus.load_half_imm_in, op_a[7:0]};
            default: result = 16'h0000;
        endcase
        if (upd_zvn) begin
`ifdef SAT_ARITH_EN
            // On overflow the true result's sign is the sign of A.
            result = ovf ? (op_a[15] ? 16'h8000 : 16'h7FFF) : arith;
`else
            result = arith;
`endif
        end
    end

    // Branch condition sees the flags from before this instruction.
    always_comb begin
        cond = 1'b0;
        unique case (bus.branch_in[2:0])
            3'b000: cond = !flag_z;
            3'b001: cond = flag_z;
            3'b010: cond = !flag_z && !flag_n;
            3'b011: cond = flag_n;
            3'b100: cond = flag_z || !flag_n;
            3'b101: cond = flag_n || flag_z;
            3'b110: cond = flag_v;
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        taken  = bus.valid_in && ((bus.branch_in[3] && cond) || bus.call_en_in);
        target = bus.call_en_in ? bus.pc_in + {{4{bus.call_in[11]}}, bus.call_in}
                                : bus.pc_in + bus.sign_ext_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q               <= 3'b000;
            bus.alu_result_out    <= 16'h0000;
            bus.store_data_out    <= 16'h0000;
            bus.mem_to_reg_out    <= 1'b0;
            bus.reg_to_mem_out    <= 1'b0;
            bus.valid_out         <= 1'b0;
            bus.branch_taken_out  <= 1'b0;
            bus.branch_target_out <= 16'h0000;
        end else if (bus.flush) begin
            // Bubble: control bits cleared, data fields and flags left as they were.
            bus.mem_to_reg_out   <= 1'b0;
            bus.reg_to_mem_out   <= 1'b0;
            bus.valid_out        <= 1'b0;
            bus.branch_taken_out <= 1'b0;
        end else if (!bus.stall) begin
            bus.alu_result_out    <= result;
            bus.store_data_out    <= bus.rd_data_1_in;
            bus.mem_to_reg_out    <= bus.mem_to_reg_in && bus.valid_in;
            bus.reg_to_mem_out    <= bus.reg_to_mem_in && bus.valid_in;
            bus.valid_out         <= bus.valid_in;
            bus.branch_taken_out  <= taken;
            bus.branch_target_out <= target;
            if (bus.valid_in && upd_zvn) begin
                flags_q <= {result == 16'h0000, ovf, result[15]};
            end else if (bus.valid_in && upd_z) begin
                flags_q[2] <= (result == 16'h0000);
            end
        end
    end

    assign bus.flags_out = flags_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage. A behavioural model tracks the
// expected registered outputs and is compared every cycle; directed literal
// checks pin the model on the key scenarios.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ex_stage_if bus ();

    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] e_alu, e_store, e_target;
    logic        e_valid, e_m2r, e_r2m, e_taken;
    logic        fz, fv, fn;
    logic        known;     // data fields defined (not after a flush)
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        logic [15:0] a, b, res;
        int t;
        logic bc;
        if (rst) begin
            e_alu = 0; e_store = 0; e_target = 0;
            e_valid = 0; e_m2r = 0; e_r2m = 0; e_taken = 0;
            fz = 0; fv = 0; fn = 0; known = 1;
        end else if (bus.flush) begin
            e_valid = 0; e_m2r = 0; e_r2m = 0; e_taken = 0; known = 0;
        end else if (!bus.stall) begin
            a = bus.rd_data_0_in;
            b = bus.alu_src_in ? bus.sign_ext_in : bus.rd_data_1_in;
            case (bus.branch_in[2:0])
                0: bc = !fz;       1: bc = fz;        2: bc = !fz && !fn;
                3: bc = fn;        4: bc = fz || !fn; 5: bc = fn || fz;
                6: bc = fv;        default: bc = 1;
            endcase
            e_taken  = bus.valid_in && ((bus.branch_in[3] && bc) || bus.call_en_in);
            t = bus.call_en_in ? int'(bus.pc_in) + int'($signed(bus.call_in))
                               : int'(bus.pc_in) + int'(bus.sign_ext_in);
            e_target = t[15:0];
            if (bus.alu_op_in <= 3'd1) begin
                t = (bus.alu_op_in == 0) ? int'($signed(a)) + int'($signed(b))
                                         : int'($signed(a)) - int'($signed(b));
                res = t[15:0];
`ifdef SAT_ARITH_EN
                if (t > 32767) res = 16'h7FFF;
                if (t < -32768) res = 16'h8000;
`endif
                if (bus.valid_in) begin
                    fz = (res == 0); fn = res[15]; fv = (t > 32767) || (t < -32768);
                end
            end else begin
                case (bus.alu_op_in)
                    2: res = a & b;
                    3: res = ~(a | b);
                    4: begin t = int'(a) << bus.shift_in; res = t[15:0]; end
                    5: begin t = int'(a) >> bus.shift_in; res = t[15:0]; end
                    6: begin t = int'($signed(a)) >>> bus.shift_in; res = t[15:0]; end
                    default: res = {bus.load_half_imm_in, a[7:0]};
                endcase
                if (bus.valid_in && bus.alu_op_in != 3'd7) fz = (res == 0);
            end
            e_alu = res; e_store = bus.rd_data_1_in;
            e_valid = bus.valid_in;
            e_m2r = bus.mem_to_reg_in && bus.valid_in;
            e_r2m = bus.reg_to_mem_in && bus.valid_in;
            known = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", {15'd0, bus.valid_out}, {15'd0, e_valid});
            check("mem_to_reg_out", {15'd0, bus.mem_to_reg_out}, {15'd0, e_m2r});
            check("reg_to_mem_out", {15'd0, bus.reg_to_mem_out}, {15'd0, e_r2m});
            check("branch_taken_out", {15'd0, bus.branch_taken_out}, {15'd0, e_taken});
            check("flags_out", {13'd0, bus.flags_out}, {13'd0, fz, fv, fn});
            if (known) begin
                check("alu_result_out", bus.alu_result_out, e_alu);
                check("store_data_out", bus.store_data_out, e_store);
                check("branch_target_out", bus.branch_target_out, e_target);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0; bus.valid_in = 0; bus.pc_in = 0;
        bus.mem_to_reg_in = 0; bus.reg_to_mem_in = 0; bus.alu_op_in = 0;
        bus.alu_src_in = 0; bus.shift_in = 0; bus.sign_ext_in = 0;
        bus.load_half_imm_in = 0; bus.branch_in = 0; bus.rd_data_0_in = 0;
        bus.rd_data_1_in = 0; bus.call_in = 0; bus.call_en_in = 0;
    endtask

    task automatic ins(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        idle();
        bus.valid_in = 1; bus.alu_op_in = op; bus.rd_data_0_in = a; bus.rd_data_1_in = b;
        tick();
    endtask

    // Branch slot uses LHB so the slot itself never touches the flags.
    task automatic br(input logic [2:0] cnd, input logic [15:0] pc, input logic [15:0] off);
        idle();
        bus.valid_in = 1; bus.alu_op_in = 3'b111; bus.branch_in = {1'b1, cnd};
        bus.pc_in = pc; bus.sign_ext_in = off;
        tick();
    endtask

    logic [2:0]  saved_flags;
    logic [15:0] setup_a [4] = '{16'd5, 16'd3, 16'h8000, 16'd7};
    logic [15:0] setup_b [4] = '{16'd5, 16'd5, 16'h0001, 16'd2};

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        chk_en = 1;
        // reset state
        check("reset alu_result", bus.alu_result_out, 16'h0000);
        check("reset flags", {13'd0, bus.flags_out}, 16'h0000);
        check("reset valid", {15'd0, bus.valid_out}, 16'h0000);
        rst = 0;

        // ADD overflow
        ins(3'b000, 16'h7FFF, 16'h0001);
`ifdef SAT_ARITH_EN
        check("add ovf result", bus.alu_result_out, 16'h7FFF);
`else
        check("add ovf result", bus.alu_result_out, 16'h8000);
`endif
        check("add ovf V", {15'd0, bus.flags_out[1]}, 16'h0001);

        // SUB to zero, then BEQ
        ins(3'b001, 16'd5, 16'd5);
        check("sub zero Z", {15'd0, bus.flags_out[2]}, 16'h0001);
        br(3'b001, 16'h0010, 16'hFFFE);
        check("beq taken", {15'd0, bus.branch_taken_out}, 16'h0001);
        check("beq target", bus.branch_target_out, 16'h000E);

        // LHB keeps flags
        saved_flags = bus.flags_out;
        idle(); bus.valid_in = 1; bus.alu_op_in = 3'b111;
        bus.rd_data_0_in = 16'h12AB; bus.load_half_imm_in = 8'hCD;
        tick();
        check("lhb result", bus.alu_result_out, 16'hCDAB);
        check("lhb flags", {13'd0, bus.flags_out}, {13'd0, saved_flags});

        // SW with stall and flush together: flush wins
        idle(); bus.valid_in = 1; bus.reg_to_mem_in = 1; bus.alu_op_in = 3'b000;
        bus.rd_data_0_in = 16'hFFFF; bus.rd_data_1_in = 16'h0001;
        bus.stall = 1; bus.flush = 1;
        tick();
        check("sw flush r2m", {15'd0, bus.reg_to_mem_out}, 16'h0000);
        check("sw flush valid", {15'd0, bus.valid_out}, 16'h0000);
        check("sw flush flags", {13'd0, bus.flags_out}, {13'd0, saved_flags});

        // SRA then 3-cycle stall with changing inputs
        idle(); bus.valid_in = 1; bus.alu_op_in = 3'b110;
        bus.rd_data_0_in = 16'h8000; bus.shift_in = 4'd4;
        tick();
        check("sra result", bus.alu_result_out, 16'hF800);
        for (int i = 0; i < 3; i++) begin
            idle(); bus.stall = 1; bus.valid_in = 1; bus.alu_op_in = 3'b000;
            bus.rd_data_0_in = 16'(i + 1); bus.rd_data_1_in = 16'h0000;
            tick();
            check("sra stall hold", bus.alu_result_out, 16'hF800);
        end

        // misc ALU ops, immediate operand, memory controls
        ins(3'b010, 16'hF0F0, 16'h0FF0);
        ins(3'b011, 16'hF0F0, 16'h0F0F);
        check("nor zero", bus.alu_result_out, 16'h0000);
        idle(); bus.valid_in = 1; bus.alu_op_in = 3'b100; bus.rd_data_0_in = 16'h0003;
        bus.shift_in = 4'd15; bus.mem_to_reg_in = 1; tick();
        check("sll", bus.alu_result_out, 16'h8000);
        idle(); bus.valid_in = 1; bus.alu_op_in = 3'b101; bus.rd_data_0_in = 16'h8000;
        bus.shift_in = 4'd3; tick();
        ins(3'b001, 16'h8000, 16'h0001);
        idle(); bus.valid_in = 1; bus.alu_src_in = 1; bus.rd_data_0_in = 16'd10;
        bus.sign_ext_in = 16'hFFF6; bus.rd_data_1_in = 16'h1234; tick();
        check("add imm zero", bus.alu_result_out, 16'h0000);

        // call with negative offset
        idle(); bus.valid_in = 1; bus.alu_op_in = 3'b111; bus.call_en_in = 1;
        bus.call_in = 12'hFFE; bus.pc_in = 16'h0005; tick();
        check("call taken", {15'd0, bus.branch_taken_out}, 16'h0001);
        check("call target", bus.branch_target_out, 16'h0003);

        // invalid slot: no effect on controls or flags
        idle(); bus.alu_op_in = 3'b001; bus.rd_data_0_in = 16'd1; bus.rd_data_1_in = 16'd1;
        bus.branch_in = 4'b1111; bus.reg_to_mem_in = 1; tick();

        // every branch condition under four flag states
        for (int s = 0; s < 4; s++) begin
            ins(3'b001, setup_a[s], setup_b[s]);
            for (int c = 0; c < 8; c++) br(3'(c), 16'h0100, 16'(c));
        end

        // reset in a stream of ADDs, with stall/flush also high
        for (int i = 0; i < 3; i++) ins(3'b000, 16'h8000, 16'h8000);
        idle(); bus.valid_in = 1; bus.stall = 1; bus.flush = 1; rst = 1;
        bus.rd_data_0_in = 16'h0001; bus.rd_data_1_in = 16'h0001; bus.mem_to_reg_in = 1;
        tick();
        check("rst alu", bus.alu_result_out, 16'h0000);
        check("rst flags", {13'd0, bus.flags_out}, 16'h0000);
        check("rst target", bus.branch_target_out, 16'h0000);
        rst = 0;
        br(3'b001, 16'h0020, 16'h0004);
        check("post-rst beq", {15'd0, bus.branch_taken_out}, 16'h0000);
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
